output_buffer_stream: RTL and testbench
=======================================

Name: output_buffer_stream

Overview:
Parametrised successor to the per-group output buffer. It captures one wide eFlash PIM result vector into a bank of NUM_GROUPS registers, each GROUP_W bits wide, with an optional zero-point add. It then drains a burst of consecutive groups to the RISC-V load path over a valid/ready handshake, using an auto-incrementing index that wraps. This replaces the one-hot load_cnt selection scheme, so the core no longer addresses each group individually.

Parameters:
NUM_GROUPS, 32, number of mapping groups in the bank (power of two, >=2)
GROUP_W, 32, width of each group and of the output data in bits
IDX_W, $clog2(NUM_GROUPS), width of a group index
CLEAR_ON_DRAIN, 1, when 1 the bank valid flag is cleared after a burst completes normally

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
output_i  in  NUM_GROUPS*GROUP_W  eFlash output vector; group i = output_i[NUM_GROUPS*GROUP_W-1-GROUP_W*i -: GROUP_W]
capture_en_i  in  1  load output_i into the bank
zero_point_en_i  in  1  add zero_point_i to every group at capture
zero_point_i  in  GROUP_W  zero-point value
start_i  in  1  request a drain burst
start_idx_i  in  IDX_W  index of the first group to send
burst_len_i  in  IDX_W+1  number of groups to send; 0 means NUM_GROUPS
abort_i  in  1  terminate the burst in progress
out_ready_i  in  1  consumer ready
out_valid_o  out  1  out_data_o is valid
out_data_o  out  GROUP_W  group data
out_idx_o  out  IDX_W  index of the group currently on out_data_o
bank_valid_o  out  1  bank holds captured, undrained data
busy_o  out  1  FSM is in DRAIN
done_o  out  1  one-cycle pulse when a burst completes
err_o  out  1  one-cycle pulse for a rejected start or a dropped capture

Behaviour:
- Reset (asynchronous, rst_ni=0):
  - State goes to IDLE.
  - Bank, out_data_o, out_idx_o and the remaining-count register are cleared to 0.
  - All 1-bit outputs are 0.
  - Reset asserted mid-burst abandons the burst: no done_o pulse, and bank_valid_o ends at 0.
- FSM states: IDLE and DRAIN.
- Capture:
  - Accepted only in IDLE.
  - On a capture_en_i cycle, bank[i] <= group_i + (zero_point_en_i ? zero_point_i : 0), computed modulo 2^GROUP_W (the carry is discarded).
  - bank_valid_o goes to 1 on the next cycle.
  - capture_en_i while in DRAIN is ignored: the bank is unchanged and err_o pulses.
- Start, IDLE -> DRAIN:
  - start_i is accepted when bank_valid_o=1 and capture_en_i=0 in the same cycle.
  - Otherwise start_i is rejected: err_o pulses and the FSM stays in IDLE.
  - If start_i and capture_en_i are both asserted, the capture wins and the start is rejected.
  - On an accepted start, the next cycle shows: busy_o=1, out_valid_o=1, out_idx_o=start_idx_i, out_data_o=bank[start_idx_i], remaining = (burst_len_i==0 ? NUM_GROUPS : burst_len_i).
  - Latency from start_i to the first valid data is 1 cycle.
- DRAIN:
  - out_valid_o stays 1. out_data_o and out_idx_o are registered and held stable while out_ready_i=0.
  - A handshake is a cycle with out_valid_o & out_ready_i.
  - On a handshake with remaining>1: out_idx_o <= (out_idx_o+1) mod NUM_GROUPS, out_data_o <= bank[new idx], remaining decrements. This sustains one group per cycle.
  - On a handshake with remaining==1: the next cycle shows out_valid_o=0, busy_o=0, done_o=1 for one cycle, and state IDLE.
  - If CLEAR_ON_DRAIN=1, bank_valid_o clears on that same cycle.
- abort_i:
  - In DRAIN: the next cycle shows IDLE with out_valid_o=0 and no done_o pulse. bank_valid_o is unchanged. The current beat is not transferred, even if out_ready_i=1 in that cycle.
  - In IDLE: no effect.
- When out_valid_o=0, out_data_o keeps its last value. The consumer must qualify data with out_valid_o.
- done_o and err_o never assert in the same cycle.

Test Plan:
- Capture groups with value 0x100+i, start idx 0 len 0, out_ready_i=1 always -> 32 beats idx 0..31 on consecutive cycles, data 0x100..0x11F, done_o on the cycle after the last beat, bank_valid_o=0.
- Start idx 30 len 4 -> beats idx 30,31,0,1 (wrap), data bank[30],bank[31],bank[0],bank[1]; done_o pulses once.
- Backpressure: toggle out_ready_i 1,0,0,1 on a len 3 burst -> out_data_o and out_idx_o stable through the stall, exactly 3 beats, no beat duplicated or skipped.
- Zero point: group value 0xFFFFFFF0, zero_point_i=0x20, zero_point_en_i=1 -> bank value 0x00000010. start_i with no prior capture -> err_o pulse, state stays IDLE.
- capture_en_i during DRAIN -> err_o pulse, drained data equals the original capture. abort_i on the 2nd beat -> out_valid_o=0 next cycle, no done_o, bank_valid_o=1.
- rst_ni low mid-burst -> all outputs 0 immediately; after release, start_i -> err_o (bank_valid_o=0).

Source files
------------

// File: rtl/output_buffer_stream_if.sv
// Group-stream handshake between the output buffer and the RISC-V load path.
//   valid : data/idx carry a group (driven by master)
//   ready : consumer accepts the current group (driven by slave)
//   data  : group payload, GROUP_W bits
//   idx   : bank index of the group on data, IDX_W bits
interface output_buffer_stream_if #(
  parameter int unsigned GROUP_W = 32,
  parameter int unsigned IDX_W   = 5
);
  logic               valid;
  logic               ready;
  logic [GROUP_W-1:0] data;
  logic [IDX_W-1:0]   idx;

  modport master (output valid, output data, output idx, input ready);
  modport slave  (input valid, input data, input idx, output ready);
endinterface

// File: rtl/output_buffer_stream.sv
// Captures one wide eFlash PIM result vector into a bank of NUM_GROUPS
// registers (optional zero-point add), then drains a burst of consecutive
// groups with a wrapping index over a valid/ready stream.
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   output_i          eFlash vector, group 0 in the most significant slice
//   capture_en_i      load output_i into the bank (IDLE only)
//   zero_point_en_i   add zero_point_i to every group at capture
//   zero_point_i      zero-point value
//   start_i           request a burst starting at start_idx_i
//   start_idx_i       first group index of the burst
//   burst_len_i       groups to send, 0 means NUM_GROUPS
//   abort_i           terminate the burst in progress
//   out_if            master side of the group stream
//   bank_valid_o      bank holds captured, undrained data
//   busy_o            burst in progress
//   done_o            one-cycle pulse on normal burst completion
//   err_o             one-cycle pulse on rejected start or dropped capture
module output_buffer_stream #(
  parameter int unsigned NUM_GROUPS     = 32,
  parameter int unsigned GROUP_W        = 32,
  parameter int unsigned IDX_W          = $clog2(NUM_GROUPS),
  parameter bit          CLEAR_ON_DRAIN = 1'b1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_GROUPS*GROUP_W-1:0] output_i,
  input  logic                          capture_en_i,
  input  logic                          zero_point_en_i,
  input  logic [GROUP_W-1:0]            zero_point_i,
  input  logic                          start_i,
  input  logic [IDX_W-1:0]              start_idx_i,
  input  logic [IDX_W:0]                burst_len_i,
  input  logic                          abort_i,
  output_buffer_stream_if.master        out_if,
  output logic                          bank_valid_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          err_o
);

  localparam int unsigned TOTAL_W = NUM_GROUPS * GROUP_W;
  localparam int unsigned CNT_W   = IDX_W + 1;

  typedef enum logic {ST_IDLE = 1'b0, ST_DRAIN = 1'b1} state_e;

  state_e             state_q;
  logic [GROUP_W-1:0] bank_q [NUM_GROUPS];
  logic [GROUP_W-1:0] grp_c  [NUM_GROUPS];
  logic [GROUP_W-1:0] zp_c;
  logic [CNT_W-1:0]   rem_q;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   idx_nxt_c;
  logic [GROUP_W-1:0] data_q;
  logic               valid_q;
  logic               bank_valid_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;

  // Slice the flat vector into groups, group 0 at the top
  for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_slice
    assign grp_c[g] = output_i[TOTAL_W-1-GROUP_W*g -: GROUP_W];
  end

  assign zp_c      = zero_point_en_i ? zero_point_i : '0;
  // Index width equals log2(NUM_GROUPS), so the increment wraps by itself
  assign idx_nxt_c = idx_q + IDX_W'(1);

  // Control FSM, bank and all registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      for (int i = 0; i < NUM_GROUPS; i++) bank_q[i] <= '0;
      rem_q        <= '0;
      idx_q        <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      bank_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (capture_en_i) begin
            // Capture wins over a simultaneous start, which is flagged
            for (int i = 0; i < NUM_GROUPS; i++) bank_q[i] <= grp_c[i] + zp_c;
            bank_valid_q <= 1'b1;
            err_q        <= start_i;
          end else if (start_i) begin
            if (bank_valid_q) begin
              state_q <= ST_DRAIN;
              valid_q <= 1'b1;
              busy_q  <= 1'b1;
              idx_q   <= start_idx_i;
              data_q  <= bank_q[start_idx_i];
              rem_q   <= (burst_len_i == '0) ? CNT_W'(NUM_GROUPS) : burst_len_i;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (abort_i) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= capture_en_i;
          end else if (out_ready_c()) begin
            if (rem_q > CNT_W'(1)) begin
              idx_q <= idx_nxt_c;
              data_q <= bank_q[idx_nxt_c];
              rem_q <= rem_q - CNT_W'(1);
              err_q <= capture_en_i;
            end else begin
              // Completion pulse takes priority over a dropped-capture flag
              state_q <= ST_IDLE;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              if (CLEAR_ON_DRAIN) bank_valid_q <= 1'b0;
            end
          end else begin
            err_q <= capture_en_i;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  function automatic logic out_ready_c();
    return out_if.ready;
  endfunction

  assign out_if.valid = valid_q;
  assign out_if.data  = data_q;
  assign out_if.idx   = idx_q;
  assign bank_valid_o = bank_valid_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_output_buffer_stream.sv
// Scoreboard bench for output_buffer_stream: expected beats are queued when
// a burst is started and compared as the stream hands them over.
module tb_output_buffer_stream;
  localparam int unsigned NG = 32;
  localparam int unsigned GW = 32;
  localparam int unsigned IW = 5;
  localparam int unsigned TW = NG * GW;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [GW-1:0] data;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [TW-1:0] output_vec = '0;
  logic          capture_en = 1'b0;
  logic          zp_en = 1'b0;
  logic [GW-1:0] zp = '0;
  logic          start = 1'b0;
  logic [IW-1:0] start_idx = '0;
  logic [IW:0]   burst_len = '0;
  logic          abort = 1'b0;
  logic          bank_valid, busy, done, err;

  output_buffer_stream_if #(.GROUP_W(GW), .IDX_W(IW)) out_if ();

  output_buffer_stream #(
    .NUM_GROUPS(NG), .GROUP_W(GW), .IDX_W(IW), .CLEAR_ON_DRAIN(1'b1)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .output_i(output_vec),
    .capture_en_i(capture_en), .zero_point_en_i(zp_en), .zero_point_i(zp),
    .start_i(start), .start_idx_i(start_idx), .burst_len_i(burst_len),
    .abort_i(abort), .out_if(out_if), .bank_valid_o(bank_valid),
    .busy_o(busy), .done_o(done), .err_o(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int start_cyc = 0;
  int beat_cnt = 0, done_cnt = 0, err_cnt = 0;
  int last_beat_cyc = 0, done_cyc = 0;
  beat_t exp_q[$];
  logic [GW-1:0] mbank [NG];
  logic [GW-1:0] cap_vals [NG];
  logic          p_stall = 1'b0;
  logic [IW-1:0] p_idx = '0;
  logic [GW-1:0] p_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Stream monitor: compares beats, checks stall stability, counts pulses
  always @(negedge clk) begin : mon
    beat_t e;
    if (rst_n) begin
      if (p_stall && out_if.valid) begin
        chk("stall_idx", 64'(out_if.idx), 64'(p_idx));
        chk("stall_data", 64'(out_if.data), 64'(p_data));
      end
      p_stall <= out_if.valid && !out_if.ready && !abort;
      p_idx   <= out_if.idx;
      p_data  <= out_if.data;
      if (out_if.valid && out_if.ready && !abort) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          chk("beat_idx", 64'(out_if.idx), 64'(e.idx));
          chk("beat_data", 64'(out_if.data), 64'(e.data));
        end
        beat_cnt      <= beat_cnt + 1;
        last_beat_cyc <= cyc;
      end
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      if (err) err_cnt <= err_cnt + 1;
      if (done || err) chk("done_err_excl", 64'(done && err), 64'd0);
    end else begin
      p_stall <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic build_vec();
    for (int i = 0; i < NG; i++) output_vec[TW-1-GW*i -: GW] = cap_vals[i];
  endtask

  task automatic do_capture(input logic en_zp, input logic [GW-1:0] zpv);
    build_vec();
    zp_en = en_zp;
    zp = zpv;
    capture_en = 1'b1;
    tick();
    capture_en = 1'b0;
    zp_en = 1'b0;
    for (int i = 0; i < NG; i++) mbank[i] = cap_vals[i] + (en_zp ? zpv : '0);
  endtask

  task automatic rand_vals();
    for (int i = 0; i < NG; i++) cap_vals[i] = $urandom;
  endtask

  task automatic do_start(input int sidx, input int len, input int npush);
    for (int k = 0; k < npush; k++) begin
      beat_t b;
      b.idx  = IW'((sidx + k) % NG);
      b.data = mbank[(sidx + k) % NG];
      exp_q.push_back(b);
    end
    start_idx = IW'(sidx);
    burst_len = (IW+1)'(len);
    start = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      tick();
      n++;
    end
    if (done_cnt == d0) chk("done_timeout", 64'(done_cnt), 64'(d0 + 1));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 64'(out_if.valid), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
    chk({tag, "_bank_valid"}, 64'(bank_valid), 64'd0);
    chk({tag, "_data"}, 64'(out_if.data), 64'd0);
    chk({tag, "_idx"}, 64'(out_if.idx), 64'd0);
  endtask

  initial begin
    int b0, d0, e0;
    out_if.ready = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Full-bank burst, len 0, continuous ready
    out_if.ready = 1'b1;
    for (int i = 0; i < NG; i++) cap_vals[i] = 32'h100 + i;
    do_capture(1'b0, '0);
    chk("cap_bank_valid", 64'(bank_valid), 64'd1);
    b0 = beat_cnt;
    d0 = done_cnt;
    do_start(0, 0, 32);
    chk("start_busy", 64'(busy), 64'd1);
    wait_done(d0, 50);
    tick();
    chk("full_beats", 64'(beat_cnt - b0), 64'd32);
    chk("full_last_cyc", 64'(last_beat_cyc), 64'(start_cyc + 32));
    chk("full_done_cyc", 64'(done_cyc), 64'(last_beat_cyc + 1));
    chk("full_q_empty", 64'(exp_q.size()), 64'd0);
    chk("full_bank_valid", 64'(bank_valid), 64'd0);
    chk("full_busy", 64'(busy), 64'd0);
    chk("full_valid", 64'(out_if.valid), 64'd0);

    // Wrapping burst from index 30
    rand_vals();
    do_capture(1'b0, '0);
    d0 = done_cnt;
    do_start(30, 4, 4);
    wait_done(d0, 20);
    tick();
    tick();
    chk("wrap_done_once", 64'(done_cnt), 64'(d0 + 1));
    chk("wrap_q_empty", 64'(exp_q.size()), 64'd0);

    // Backpressure on a len 3 burst
    rand_vals();
    do_capture(1'b0, '0);
    b0 = beat_cnt;
    d0 = done_cnt;
    do_start(5, 3, 3);
    out_if.ready = 1'b1; tick();
    out_if.ready = 1'b0; tick();
    out_if.ready = 1'b0; tick();
    out_if.ready = 1'b1; tick();
    wait_done(d0, 10);
    tick();
    chk("bp_beats", 64'(beat_cnt - b0), 64'd3);
    chk("bp_q_empty", 64'(exp_q.size()), 64'd0);

    // Start without data, then capture+start collision with zero point
    chk("nocap_bank_valid", 64'(bank_valid), 64'd0);
    e0 = err_cnt;
    do_start(0, 1, 0);
    tick();
    chk("nocap_err", 64'(err_cnt), 64'(e0 + 1));
    chk("nocap_busy", 64'(busy), 64'd0);
    for (int i = 0; i < NG; i++) cap_vals[i] = 32'hFFFF_FFF0;
    build_vec();
    zp_en = 1'b1;
    zp = 32'h20;
    capture_en = 1'b1;
    start = 1'b1;
    tick();
    capture_en = 1'b0;
    start = 1'b0;
    zp_en = 1'b0;
    for (int i = 0; i < NG; i++) mbank[i] = 32'h0000_0010;
    tick();
    chk("coll_err", 64'(err_cnt), 64'(e0 + 2));
    chk("coll_busy", 64'(busy), 64'd0);
    chk("coll_bank_valid", 64'(bank_valid), 64'd1);
    d0 = done_cnt;
    do_start(7, 2, 2);
    wait_done(d0, 10);
    tick();
    chk("zp_q_empty", 64'(exp_q.size()), 64'd0);

    // Capture during drain is dropped
    rand_vals();
    do_capture(1'b0, '0);
    d0 = done_cnt;
    e0 = err_cnt;
    do_start(0, 4, 4);
    rand_vals();
    build_vec();
    capture_en = 1'b1;
    tick();
    capture_en = 1'b0;
    wait_done(d0, 10);
    tick();
    chk("drop_err", 64'(err_cnt), 64'(e0 + 1));
    chk("drop_done", 64'(done_cnt), 64'(d0 + 1));
    chk("drop_q_empty", 64'(exp_q.size()), 64'd0);

    // Abort on the second beat
    rand_vals();
    do_capture(1'b0, '0);
    d0 = done_cnt;
    do_start(0, 8, 1);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", 64'(out_if.valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_bank_valid", 64'(bank_valid), 64'd1);
    tick();
    tick();
    chk("abort_no_done", 64'(done_cnt), 64'(d0));
    chk("abort_q_empty", 64'(exp_q.size()), 64'd0);

    // Reset in the middle of a burst
    d0 = done_cnt;
    do_start(3, 0, 32);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    e0 = err_cnt;
    do_start(0, 0, 0);
    tick();
    chk("postrst_err", 64'(err_cnt), 64'(e0 + 1));
    chk("postrst_bank_valid", 64'(bank_valid), 64'd0);
    chk("postrst_busy", 64'(busy), 64'd0);
    chk("postrst_no_done", 64'(done_cnt), 64'(d0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
